dac_spi_array_ctrl: RTL
=======================

// Module: dac_spi_array_ctrl
// PURPOSE
//  Parametrised serial loader for an array of AD5328-family octal DACs (AD5308/5318/5328) sharing SCLK, DIN and LDAC_N.
//  Each chip has its own SYNC_N line.
//  On dac_update it snapshots all channel codes and writes only the channels whose code changed since the last write.
//  It then pulses LDAC_N to update all outputs together.
//  Sits between the slow-control register file and the front-end bias DACs, in the dtc_clk domain.
// PARAMETERS
//  N_CHIPS    4   number of DAC chips, 1..16
//  CH_PER     8   channels per chip, 1..8 (address field A2..A0)
//  DATA_W     12  DAC code width (8, 10 or 12)
//  CLK_DIV    2   dtc_clk cycles per SCLK half-period, >=1
//  GAP_CYC    4   dtc_clk cycles SYNC_N stays high between frames, >=1
//  LDAC_CYC   2   dtc_clk cycles LDAC_N is held low, >=1
//  WRITE_ALL  0   1 = disable change detection, so every update writes every channel
// PORTS
//  dtc_clk     in   1                       system clock
//  rst         in   1                       asynchronous active-high reset
//  dac_data    in   [N_CHIPS*CH_PER][DATA_W] channel codes; index = chip*CH_PER+ch
//  dac_update  in   1                       one-cycle request to load dac_data
//  force_all   in   1                       sampled with dac_update: write all channels this pass
//  busy        out  1                       high from the cycle after the accepted request to the cycle done pulses
//  done        out  1                       one-cycle pulse when a pass completes
//  n_written   out  8                       number of frames sent in the last pass, valid at done
//  din         out  1                       serial data, MSB first
//  sync_n      out  [N_CHIPS]               per-chip frame select, active low
//  ldac_n      out  1                       common load strobe, active low
//  sclk        out  1                       serial clock, idle high
// BEHAVIOUR
//  Reset values: sync_n all 1, sclk 1, din 0, ldac_n 1, busy 0, done 0, n_written 0.
//  Reset also clears the shadow (last-written) array and marks it invalid, so the first pass after reset writes all channels.
//  Frame (16 bit): {1'b0, addr[2:0], code, zero pad}. The code is left-justified in bits 11:0; pad = 12-DATA_W LSBs.
//  Request handling:
//   - dac_update while idle: dac_data is snapshotted on that edge; busy rises on the next cycle.
//   - dac_update while busy: sets a one-deep pending flag (with force_all OR-ed in). Further requests merge into it.
//   - Pending request: on completion, done pulses; busy drops for exactly one cycle; the snapshot is taken in that idle cycle; busy rises again on the next cycle.
//  FSM:
//   - IDLE -> SCAN on an accepted request.
//   - SCAN: walks channel index 0..N-1, one index per clock.
//     - A channel is selected if code != shadow, or shadow is invalid, or force_all, or WRITE_ALL. Selected -> SETUP.
//     - After the last index: LDAC if n_written > 0, else FIN.
//   - SETUP: sync_n[chip] goes low and din = bit15; sclk stays high for CLK_DIV cycles -> SHIFT.
//   - SHIFT: 16 SCLK periods.
//     - sclk falls: the DAC samples din. sclk rises: din advances to the next bit.
//     - Each half-period is CLK_DIV cycles.
//     - After the 16th falling edge, sclk returns high after CLK_DIV cycles.
//     - Then sync_n goes high, the shadow entry is updated and n_written increments -> GAP.
//   - GAP: GAP_CYC cycles with all sync_n high -> SCAN, resuming at index+1.
//   - LDAC: ldac_n low for LDAC_CYC cycles -> FIN.
//   - FIN: done = 1 for one cycle; the shadow is marked valid -> IDLE, or accept the pending request.
//  At most one sync_n bit is low at any time. sync_n never toggles while sclk is low.
//  n_written saturates at 255. It is cleared at the start of each pass.
//  Reset mid-frame: all outputs return to reset values immediately (async). The partial frame is discarded; the DAC ignores frames shorter than 16 bits.
//  dac_data changes after the snapshot have no effect on the current pass.
// TESTING
//  1. Reset, then update with ch k = k (defaults): 32 frames; chip 0 first, addr 0..7; frame ch9 = 16'h1009 on sync_n[1].
//     Then ldac_n low 2 cycles, done, n_written = 32.
//  2. Repeat the update with unchanged data: no sync_n activity, no ldac_n pulse; done arrives within 34 cycles; n_written = 0.
//  3. Change ch5 to 12'hABC and ch30 to 12'h123, then update: exactly 2 frames.
//     16'h5ABC on sync_n[0] and 16'h6123 on sync_n[3]; n_written = 2.
//  4. Two updates while busy plus one with force_all: a single extra pass follows after a one-cycle busy gap; n_written = 32.
//  5. Assert rst during the 8th bit of a frame: sync_n = 4'hF, sclk = 1, ldac_n = 1 asynchronously.
//     The next update writes all 32 channels.
//  6. DATA_W = 8, CLK_DIV = 1, N_CHIPS = 1: code 8'hA5 on ch3 gives frame 16'h3A50, SCLK period 2 cycles, n_written = 8 after the first update.

Source files
------------

// File: rtl/dac_spi_array_ctrl.sv
// Serial loader for an array of AD5308/5318/5328 octal DACs sharing SCLK, DIN and LDAC_N.
// Each pass writes only the channels whose code differs from the last value written, then strobes LDAC_N.
module dac_spi_array_ctrl #(
    parameter int N_CHIPS   = 4,
    parameter int CH_PER    = 8,
    parameter int DATA_W    = 12,
    parameter int CLK_DIV   = 2,
    parameter int GAP_CYC   = 4,
    parameter int LDAC_CYC  = 2,
    parameter bit WRITE_ALL = 1'b0
) (
    input  logic                             dtc_clk,
    input  logic                             rst,
    input  logic [N_CHIPS*CH_PER*DATA_W-1:0] dac_data,
    input  logic                             dac_update,
    input  logic                             force_all,
    output logic                             busy,
    output logic                             done,
    output logic [7:0]                       n_written,
    output logic                             din,
    output logic [N_CHIPS-1:0]               sync_n,
    output logic                             ldac_n,
    output logic                             sclk
);

    localparam int N_CH  = N_CHIPS * CH_PER;
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
    localparam logic [2:0]       CH_LAST  = 3'(CH_PER - 1);
    localparam logic [15:0]      DIV_END  = 16'(CLK_DIV - 1);
    localparam logic [15:0]      GAP_END  = 16'(GAP_CYC - 1);
    localparam logic [15:0]      LDAC_END = 16'(LDAC_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SETUP,
        SHIFT,
        GAP,
        LDAC,
        FIN
    } state_t;

    state_t state;

    logic [DATA_W-1:0] snap   [N_CH];
    logic [DATA_W-1:0] shadow [N_CH];
    logic              shadow_valid;

    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [3:0]        chip_idx;
    logic [3:0]        chip_nxt;
    logic [2:0]        ch_idx;
    logic [2:0]        ch_nxt;

    logic [15:0]       cnt;
    logic [3:0]        bit_cnt;
    logic [14:0]       shift_reg;

    logic              force_pass;
    logic              pending;
    logic              pend_force;
    logic              accept;
    logic              selected;

    logic [DATA_W-1:0] cur_code;
    logic [11:0]       code_just;
    logic [15:0]       frame;

    // A queued request is served from IDLE exactly like a fresh one, which gives the one-cycle busy gap.
    assign accept    = (state == IDLE) && (dac_update || pending);
    assign cur_code  = snap[idx];
    assign code_just = 12'(cur_code) << (12 - DATA_W);
    assign frame     = {1'b0, ch_idx, code_just};
    assign selected  = force_pass || !shadow_valid || (cur_code != shadow[idx]);

    always_comb begin
        idx_nxt = idx + 1'b1;
        if (ch_idx == CH_LAST) begin
            ch_nxt   = '0;
            chip_nxt = chip_idx + 1'b1;
        end else begin
            ch_nxt   = ch_idx + 1'b1;
            chip_nxt = chip_idx;
        end
    end

    always_ff @(posedge dtc_clk) begin
        if (accept) begin
            for (int i = 0; i < N_CH; i++) begin
                snap[i] <= dac_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge dtc_clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            chip_idx     <= '0;
            ch_idx       <= '0;
            cnt          <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            force_pass   <= 1'b0;
            pending      <= 1'b0;
            pend_force   <= 1'b0;
            shadow_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            n_written    <= '0;
            din          <= 1'b0;
            sync_n       <= '1;
            ldac_n       <= 1'b1;
            sclk         <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (state != IDLE && dac_update) begin
                pending    <= 1'b1;
                pend_force <= pend_force | force_all;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= SCAN;
                        busy       <= 1'b1;
                        n_written  <= '0;
                        idx        <= '0;
                        chip_idx   <= '0;
                        ch_idx     <= '0;
                        force_pass <= WRITE_ALL | (dac_update & force_all) | (pending & pend_force);
                        pending    <= 1'b0;
                        pend_force <= 1'b0;
                    end
                end

                SCAN: begin
                    if (selected) begin
                        state     <= SETUP;
                        sync_n    <= ~(N_CHIPS'(1) << chip_idx);
                        din       <= frame[15];
                        shift_reg <= frame[14:0];
                        cnt       <= '0;
                    end else if (idx == LAST_IDX) begin
                        if (n_written != 8'd0) begin
                            state  <= LDAC;
                            ldac_n <= 1'b0;
                            cnt    <= '0;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end else begin
                        idx      <= idx_nxt;
                        chip_idx <= chip_nxt;
                        ch_idx   <= ch_nxt;
                    end
                end

                SETUP: begin
                    if (cnt == DIV_END) begin
                        state   <= SHIFT;
                        sclk    <= 1'b0;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // The DAC samples on the falling edge, so din only moves while sclk goes high.
                SHIFT: begin
                    if (cnt != DIV_END) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (!sclk) begin
                            sclk      <= 1'b1;
                            din       <= shift_reg[14];
                            shift_reg <= {shift_reg[13:0], 1'b0};
                        end else if (bit_cnt == 4'd15) begin
                            state       <= GAP;
                            sync_n      <= '1;
                            din         <= 1'b0;
                            shadow[idx] <= cur_code;
                            if (n_written != 8'hFF) begin
                                n_written <= n_written + 1'b1;
                            end
                        end else begin
                            sclk    <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                GAP: begin
                    if (cnt == GAP_END) begin
                        cnt <= '0;
                        if (idx == LAST_IDX) begin
                            state  <= LDAC;
                            ldac_n <= 1'b0;
                        end else begin
                            state    <= SCAN;
                            idx      <= idx_nxt;
                            chip_idx <= chip_nxt;
                            ch_idx   <= ch_nxt;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                LDAC: begin
                    if (cnt == LDAC_END) begin
                        ldac_n <= 1'b1;
                        state  <= FIN;
                        done   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                FIN: begin
                    busy         <= 1'b0;
                    shadow_valid <= 1'b1;
                    state        <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
